// File: rtl/fetch_iq.sv
// Fetch stage: issues one-outstanding instruction-memory reads and buffers the returned
// words in a DEPTH-entry queue drained by decode; redirects flush and drop in-flight data.
module fetch_iq #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  output logic [3:0]                 imem_rmask,
  input  logic [31:0]                imem_rdata,
  input  logic                       imem_resp,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_pc,
  output logic [31:0]                deq_pc_next,
  output logic [$clog2(DEPTH+1)-1:0] iq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SPARE = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic             issue;
  logic             enq;
  logic             pop;

  // A request from WAIT must leave room for the response that is arriving now,
  // so enqueue can never overflow the queue.
  always_comb begin
    // NOTE: default first so every path assigns issue and no latch is inferred.
    issue = 1'b0;
    if (!rst && !redirect) begin
      case (state)
        IDLE:    issue = (count < FULL);
        WAIT:    issue = imem_resp && (count < SPARE);
        DISCARD: issue = imem_resp;
        default: issue = 1'b0;
      endcase
    end
  end

  assign enq = !redirect && imem_resp && (state == WAIT);
  assign pop = !redirect && deq_valid && deq_ready;

  assign imem_addr  = fetch_pc;
  assign imem_rmask = issue ? 4'hF : 4'h0;

  assign deq_valid   = (count != '0);
  assign deq_instr   = deq_valid ? instr_q[rd_ptr] : '0;
  assign deq_pc      = deq_valid ? pc_q[rd_ptr] : '0;
  assign deq_pc_next = deq_valid ? pc_q[rd_ptr] + 32'd4 : '0;
  assign iq_count    = count;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= rd_ptr;
      count    <= '0;
      // An outstanding request whose data has not yet arrived must be drained and dropped.
      if (imem_resp || state == IDLE) state <= IDLE;
      else                            state <= DISCARD;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !pop)      count <= count + CNT_W'(1);
      else if (pop && !enq) count <= count - CNT_W'(1);
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
        state    <= WAIT;
      end else if (state == WAIT && imem_resp) begin
        state <= IDLE;
      end
    end
  end

  // NOTE: queue storage is not reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_iq.sv
// Self-checking bench for fetch_iq: directed vector table, hand-written corner sequences,
// and randomized traffic checked by a queue/epoch scoreboard of the fetch contract.
module tb_fetch_iq;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int          DEPTH    = 4;
  localparam int          CNT_W    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic [31:0]      imem_rdata;
  logic             imem_resp;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             deq_ready;
  logic             deq_valid;
  logic [31:0]      deq_instr;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_pc_next;
  logic [CNT_W-1:0] iq_count;

  fetch_iq #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_pc_next(deq_pc_next),
    .iq_count(iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13579bdf;
  endfunction

  // Scoreboard: what decode should see, plus the fetch-address contract
  typedef struct {logic [31:0] pc; logic [31:0] instr;} entry_t;
  entry_t      q[$];
  bit          outstanding;
  int          out_tag;
  logic [31:0] out_pc;
  int          epoch;
  logic [31:0] exp_addr;

  // Memory responder
  bit          auto_resp;
  int          lat_min, lat_max;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  // Observations of the last cycle
  logic [31:0] deq_pc_log[$];
  logic [31:0] deq_instr_log[$];
  logic [3:0]  obs_rmask;
  logic [31:0] obs_addr, obs_pc, obs_instr;
  logic        obs_valid;
  int          obs_count, max_count, n_req;

  task automatic model_reset();
    q.delete();
    outstanding = 0;
    out_tag     = 0;
    out_pc      = '0;
    epoch       = 0;
    exp_addr    = RESET_PC;
    pend        = 0;
  endtask

  task automatic model_step();
    bit kept, exp_issue, do_pop;
    int sz;
    sz = q.size();
    check("iq_count", 32'(iq_count), 32'(sz));
    check("deq_valid", 32'(deq_valid), 32'(sz != 0));
    if (sz != 0) begin
      check("deq_pc", deq_pc, q[0].pc);
      check("deq_instr", deq_instr, q[0].instr);
      check("deq_pc_next", deq_pc_next, q[0].pc + 32'd4);
    end
    kept      = !redirect && imem_resp && outstanding && (out_tag == epoch);
    exp_issue = !redirect && (!outstanding || imem_resp) && ((sz + int'(kept)) < DEPTH);
    check("imem_rmask", 32'(imem_rmask), exp_issue ? 32'hF : 32'h0);
    check("imem_addr", imem_addr, exp_addr);
    if (redirect) begin
      q.delete();
      epoch++;
      outstanding = outstanding && !imem_resp;
      exp_addr    = redirect_pc;
    end else begin
      do_pop = (sz != 0) && deq_ready;
      if (imem_resp && outstanding) begin
        if (kept) q.push_back('{pc: out_pc, instr: imem_rdata});
        outstanding = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (exp_issue) begin
        outstanding = 1;
        out_tag     = epoch;
        out_pc      = exp_addr;
        exp_addr    = exp_addr + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    obs_rmask = imem_rmask;
    obs_addr  = imem_addr;
    obs_valid = deq_valid;
    obs_count = int'(iq_count);
    obs_pc    = deq_pc;
    obs_instr = deq_instr;
    if (obs_count > max_count) max_count = obs_count;
    if (imem_rmask == 4'hF) n_req++;
    if (!rst && !redirect && deq_valid && deq_ready) begin
      deq_pc_log.push_back(deq_pc);
      deq_instr_log.push_back(deq_instr);
    end
    if (!rst) model_step();
    if (auto_resp && imem_rmask == 4'hF) begin
      pend      = 1;
      pend_addr = imem_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min);
    end
    @(posedge clk);
    #1;
    if (auto_resp) begin
      imem_resp = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = data_of(pend_addr);
          pend       = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    deq_ready   = 1'b0;
    imem_resp   = 1'b0;
    imem_rdata  = '0;
    auto_resp   = 1;
    lat_min     = 1;
    lat_max     = 1;
    model_reset();
    deq_pc_log.delete();
    deq_instr_log.delete();
    max_count = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst imem_rmask", 32'(imem_rmask), 32'h0);
    check("rst imem_addr", imem_addr, RESET_PC);
    check("rst deq_valid", 32'(deq_valid), 32'h0);
    check("rst iq_count", 32'(iq_count), 32'h0);
    check("rst deq_instr", deq_instr, 32'h0);
    check("rst deq_pc", deq_pc, 32'h0);
    check("rst deq_pc_next", deq_pc_next, 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic [3:0]  rmask;
    logic [31:0] addr;
    logic        valid;
    int          count;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req_start;

    // Fill with decode stalled, then release a single entry.
    vecs[0]  = '{1'b0, 4'hF, 32'h1eceb000, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h1eceb004, 1'b0, 0, 32'h0};
    vecs[2]  = '{1'b0, 4'hF, 32'h1eceb008, 1'b1, 1, 32'h1eceb000};
    vecs[3]  = '{1'b0, 4'hF, 32'h1eceb00c, 1'b1, 2, 32'h1eceb000};
    vecs[4]  = '{1'b0, 4'h0, 32'h1eceb010, 1'b1, 3, 32'h1eceb000};
    vecs[5]  = '{1'b0, 4'h0, 32'h1eceb010, 1'b1, 4, 32'h1eceb000};
    vecs[6]  = '{1'b0, 4'h0, 32'h1eceb010, 1'b1, 4, 32'h1eceb000};
    vecs[7]  = '{1'b1, 4'h0, 32'h1eceb010, 1'b1, 4, 32'h1eceb000};
    vecs[8]  = '{1'b0, 4'hF, 32'h1eceb010, 1'b1, 3, 32'h1eceb004};
    vecs[9]  = '{1'b0, 4'h0, 32'h1eceb014, 1'b1, 3, 32'h1eceb004};
    vecs[10] = '{1'b0, 4'h0, 32'h1eceb014, 1'b1, 4, 32'h1eceb004};

    n_req = 0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      deq_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d rmask", i), 32'(obs_rmask), 32'(vecs[i].rmask));
      check($sformatf("vec%0d addr", i), obs_addr, vecs[i].addr);
      check($sformatf("vec%0d valid", i), 32'(obs_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d count", i), 32'(obs_count), 32'(vecs[i].count));
      if (vecs[i].valid) check($sformatf("vec%0d pc", i), obs_pc, vecs[i].pc);
    end

    // Streaming with a one-cycle memory and decode always ready.
    do_reset();
    deq_ready = 1'b1;
    for (int i = 0; i < 20 && deq_pc_log.size() < 3; i++) tick();
    check("stream delivered", 32'(deq_pc_log.size() >= 3), 32'h1);
    for (int k = 0; k < 3 && k < deq_pc_log.size(); k++) begin
      check($sformatf("stream pc%0d", k), deq_pc_log[k], RESET_PC + 32'(4 * k));
      check($sformatf("stream instr%0d", k), deq_instr_log[k], data_of(RESET_PC + 32'(4 * k)));
    end

    // Redirect while waiting; the late response must be discarded.
    do_reset();
    auto_resp = 0;
    deq_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h2000;
    tick();
    check("wait redirect rmask", 32'(obs_rmask), 32'h0);
    redirect = 1'b0;
    tick();
    tick();
    imem_resp = 1'b1; imem_rdata = 32'hdeadbeef;
    tick();
    check("discard reissue rmask", 32'(obs_rmask), 32'hF);
    check("discard reissue addr", obs_addr, 32'h2000);
    imem_resp = 1'b1; imem_rdata = data_of(32'h2000);
    tick();
    imem_resp = 1'b0;
    tick();
    check("after discard valid", 32'(obs_valid), 32'h1);
    check("after discard pc", obs_pc, 32'h2000);
    check("after discard instr", obs_instr, data_of(32'h2000));
    foreach (deq_instr_log[k]) check("stale data dequeued", 32'(deq_instr_log[k] == 32'hdeadbeef), 32'h0);

    // Redirect coinciding with a response while two entries are queued.
    do_reset();
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h3000; deq_ready = 1'b1;
    tick();
    check("coincide count before", 32'(obs_count), 32'h2);
    check("coincide rmask", 32'(obs_rmask), 32'h0);
    redirect = 1'b0; deq_ready = 1'b0;
    tick();
    check("coincide flushed count", 32'(obs_count), 32'h0);
    check("coincide rmask next", 32'(obs_rmask), 32'hF);
    check("coincide addr next", obs_addr, 32'h3000);

    // Ten instructions with decode ready toggling, across pointer wrap.
    do_reset();
    for (int i = 0; i < 200 && deq_pc_log.size() < 10; i++) begin
      deq_ready = (i % 2 == 0);
      tick();
    end
    check("toggle delivered", 32'(deq_pc_log.size() >= 10), 32'h1);
    for (int k = 0; k < 10 && k < deq_pc_log.size(); k++) begin
      check($sformatf("toggle pc%0d", k), deq_pc_log[k], RESET_PC + 32'(4 * k));
      check($sformatf("toggle instr%0d", k), deq_instr_log[k], data_of(RESET_PC + 32'(4 * k)));
    end
    check("toggle max count", 32'(max_count <= DEPTH), 32'h1);

    // Reset mid-request; the stale response after release is ignored.
    do_reset();
    auto_resp = 0;
    tick();
    check("pre-reset rmask", 32'(obs_rmask), 32'hF);
    rst = 1'b1;
    model_reset();
    #1;
    check("async rst imem_addr", imem_addr, RESET_PC);
    check("async rst rmask", 32'(imem_rmask), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; imem_resp = 1'b1; imem_rdata = 32'hdeadbeef;
    tick();
    check("post-reset rmask", 32'(obs_rmask), 32'hF);
    check("post-reset addr", obs_addr, RESET_PC);
    imem_resp = 1'b0;
    tick();
    check("stale resp count", 32'(obs_count), 32'h0);
    check("stale resp valid", 32'(obs_valid), 32'h0);

    // Randomized traffic against the scoreboard.
    do_reset();
    lat_min = 1; lat_max = 3;
    n_req_start = n_req;
    for (int i = 0; i < 3000; i++) begin
      deq_ready = ($urandom_range(3, 0) != 0);
      redirect  = ($urandom_range(19, 0) == 0);
      if ($urandom_range(7, 0) == 0) redirect_pc = 32'hfffffff8;
      else                           redirect_pc = $urandom() & 32'hfffffffc;
      tick();
    end
    redirect = 1'b0;
    check("random liveness", 32'(n_req - n_req_start > 300), 32'h1);
    check("random max count", 32'(max_count <= DEPTH), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
